ppu_job_arbiter: RTL and testbench

- Shares a single ppu datapath between NREQ requesters, typically systolic-array output banks.
- Each requester submits one job: a scale/bias config plus BEATS partial-sum vectors.
- The block grants round-robin, latches the job config and streams the beats to the PPU, then waits for the PPU done pulse.
- It returns the 128-bit result to the winning requester with an ID, or flags a timeout error if done never arrives.

---
 rtl/ppu_job_arbiter.sv | 144 ++++++++++++++
 tb/tb_ppu_job_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_job_arbiter.sv
// Round-robin arbiter that hands one shared PPU datapath to NREQ requesters:
// grant, stream BEATS partial-sum beats, wait for the PPU result, respond.
module ppu_job_arbiter #(
  parameter int NREQ    = 2,
  parameter int BEATS   = 16,
  parameter int TIMEOUT = 1023,
  parameter int PSUM_W  = 384,
  localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_i,
  input  logic [NREQ*16-1:0]       req_cfg_i,
  input  logic [NREQ*PSUM_W-1:0]   req_psum_i,
  input  logic [NREQ-1:0]          req_psum_valid_i,
  output logic [NREQ-1:0]          gnt_o,
  output logic [PSUM_W-1:0]        ppu_psum_o,
  output logic [7:0]               ppu_scale_o,
  output logic [7:0]               ppu_bias_o,
  output logic                     ppu_valid_o,
  input  logic                     ppu_done_i,
  input  logic [127:0]             ppu_data_i,
  output logic                     rsp_valid_o,
  output logic [IDW-1:0]           rsp_id_o,
  output logic [127:0]             rsp_data_o,
  output logic                     rsp_err_o,
  output logic                     busy_o
);

  localparam int BCW = $clog2(BEATS) + 1;
  localparam int WCW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, STREAM, WAIT_DONE, RESP} state_t;

  state_t          state_reg;
  logic [IDW-1:0]  gid_reg;
  logic [IDW-1:0]  ptr_reg;
  logic [BCW-1:0]  beat_cnt_reg;
  logic [WCW-1:0]  wait_cnt_reg;
  logic [WCW-1:0]  wait_cnt_next;

  logic [15:0]       cfg_arr  [NREQ];
  logic [PSUM_W-1:0] psum_arr [NREQ];

  logic            pick_valid;
  logic [IDW-1:0]  pick_id;
  logic [IDW-1:0]  cand;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign cfg_arr[gi]  = req_cfg_i[gi*16 +: 16];
      assign psum_arr[gi] = req_psum_i[gi*PSUM_W +: PSUM_W];
    end
  endgenerate

  // Scan from the farthest candidate back to ptr+1 so the nearest requester wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int i = NREQ; i >= 1; i--) begin
      cand = IDW'((int'(ptr_reg) + i) % NREQ);
      if (req_i[cand]) begin
        pick_valid = 1'b1;
        pick_id    = cand;
      end
    end
  end

  assign wait_cnt_next = (wait_cnt_reg == {WCW{1'b1}}) ? wait_cnt_reg : wait_cnt_reg + 1'b1;

  assign ppu_psum_o  = psum_arr[gid_reg];
  assign ppu_valid_o = (state_reg == STREAM) && req_psum_valid_i[gid_reg];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      gid_reg      <= '0;
      ptr_reg      <= IDW'(NREQ - 1);
      beat_cnt_reg <= '0;
      wait_cnt_reg <= '0;
      gnt_o        <= '0;
      ppu_scale_o  <= '0;
      ppu_bias_o   <= '0;
      rsp_valid_o  <= 1'b0;
      rsp_id_o     <= '0;
      rsp_data_o   <= '0;
      rsp_err_o    <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            gid_reg      <= pick_id;
            ppu_scale_o  <= cfg_arr[pick_id][15:8];
            ppu_bias_o   <= cfg_arr[pick_id][7:0];
            gnt_o        <= NREQ'(1) << pick_id;
            busy_o       <= 1'b1;
            beat_cnt_reg <= '0;
            state_reg    <= STREAM;
          end
        end
        STREAM: begin
          if (ppu_valid_o) begin
            beat_cnt_reg <= beat_cnt_reg + 1'b1;
            if (beat_cnt_reg == BCW'(BEATS - 1)) begin
              wait_cnt_reg <= '0;
              state_reg    <= WAIT_DONE;
            end
          end
        end
        WAIT_DONE: begin
          // A done arriving on the limit cycle still counts as success.
          if (ppu_done_i) begin
            rsp_data_o  <= ppu_data_i;
            rsp_err_o   <= 1'b0;
            rsp_id_o    <= gid_reg;
            rsp_valid_o <= 1'b1;
            state_reg   <= RESP;
          end else begin
            wait_cnt_reg <= wait_cnt_next;
            if (wait_cnt_next == WCW'(TIMEOUT)) begin
              rsp_data_o  <= '0;
              rsp_err_o   <= 1'b1;
              rsp_id_o    <= gid_reg;
              rsp_valid_o <= 1'b1;
              state_reg   <= RESP;
            end
          end
        end
        RESP: begin
          rsp_valid_o <= 1'b0;
          gnt_o       <= '0;
          busy_o      <= 1'b0;
          ptr_reg     <= gid_reg;
          state_reg   <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ppu_job_arbiter.sv
// Directed bench for ppu_job_arbiter: a job-level reference model checked every
// cycle, plus literal expectations for grant order, beat counts and timeout.
module tb_ppu_job_arbiter;
  localparam int NREQ = 2, BEATS = 16, TIMEOUT = 1023, PSUM_W = 384;
  localparam int P_IDLE = 0, P_STREAM = 1, P_WAIT = 2, P_RESP = 3;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NREQ-1:0]        req_i = '0;
  logic [NREQ*16-1:0]     req_cfg_i = '0;
  logic [NREQ*PSUM_W-1:0] req_psum_i = '0;
  logic [NREQ-1:0]        req_psum_valid_i = '0;
  logic [NREQ-1:0]        gnt_o;
  logic [PSUM_W-1:0]      ppu_psum_o;
  logic [7:0]             ppu_scale_o, ppu_bias_o;
  logic                   ppu_valid_o;
  logic                   ppu_done_i = 1'b0;
  logic [127:0]           ppu_data_i = '0;
  logic                   rsp_valid_o;
  logic [0:0]             rsp_id_o;
  logic [127:0]           rsp_data_o;
  logic                   rsp_err_o;
  logic                   busy_o;

  ppu_job_arbiter #(.NREQ(NREQ), .BEATS(BEATS), .TIMEOUT(TIMEOUT), .PSUM_W(PSUM_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .req_cfg_i(req_cfg_i),
    .req_psum_i(req_psum_i), .req_psum_valid_i(req_psum_valid_i), .gnt_o(gnt_o),
    .ppu_psum_o(ppu_psum_o), .ppu_scale_o(ppu_scale_o), .ppu_bias_o(ppu_bias_o),
    .ppu_valid_o(ppu_valid_o), .ppu_done_i(ppu_done_i), .ppu_data_i(ppu_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_id_o(rsp_id_o), .rsp_data_o(rsp_data_o),
    .rsp_err_o(rsp_err_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_total = 0, n_bad = 0;

  task automatic chk(input string name, input logic [PSUM_W-1:0] act, input logic [PSUM_W-1:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Job-level reference model: phase, owner, beats seen, cycles waited.
  int           m_phase = P_IDLE, m_ptr = NREQ - 1, m_gid = 0, m_beats = 0, m_waited = 0, m_c;
  bit           m_found;
  logic [7:0]   m_scale = '0, m_bias = '0;
  logic         m_rv = 1'b0, m_rerr = 1'b0;
  int           m_rid = 0;
  logic [127:0] m_rdata = '0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_phase = P_IDLE; m_ptr = NREQ - 1; m_gid = 0; m_beats = 0; m_waited = 0;
      m_scale = '0; m_bias = '0; m_rv = 1'b0; m_rid = 0; m_rdata = '0; m_rerr = 1'b0;
    end else begin
      case (m_phase)
        P_IDLE: if (req_i != '0) begin
          m_found = 1'b0;
          for (int k = 1; k <= NREQ; k++) begin
            m_c = (m_ptr + k) % NREQ;
            if (!m_found && req_i[m_c]) begin m_found = 1'b1; m_gid = m_c; end
          end
          m_scale = req_cfg_i[m_gid*16+8 +: 8];
          m_bias  = req_cfg_i[m_gid*16 +: 8];
          m_beats = 0;
          m_phase = P_STREAM;
        end
        P_STREAM: if (req_psum_valid_i[m_gid]) begin
          m_beats++;
          if (m_beats == BEATS) begin m_phase = P_WAIT; m_waited = 0; end
        end
        P_WAIT: if (ppu_done_i) begin
          m_rv = 1'b1; m_rid = m_gid; m_rdata = ppu_data_i; m_rerr = 1'b0; m_phase = P_RESP;
        end else begin
          m_waited++;
          if (m_waited >= TIMEOUT) begin
            m_rv = 1'b1; m_rid = m_gid; m_rdata = '0; m_rerr = 1'b1; m_phase = P_RESP;
          end
        end
        default: begin m_rv = 1'b0; m_ptr = m_gid; m_phase = P_IDLE; end
      endcase
    end
  end

  // Per-cycle compare against the model.
  logic [NREQ-1:0] exp_gnt;
  initial forever begin
    @(negedge clk);
    exp_gnt = '0;
    if (m_phase != P_IDLE) exp_gnt[m_gid] = 1'b1;
    chk("gnt", gnt_o, exp_gnt);
    chk("busy", busy_o, m_phase != P_IDLE);
    chk("scale", ppu_scale_o, m_scale);
    chk("bias", ppu_bias_o, m_bias);
    chk("ppu_valid", ppu_valid_o, (m_phase == P_STREAM) && req_psum_valid_i[m_gid]);
    chk("ppu_psum", ppu_psum_o, req_psum_i[m_gid*PSUM_W +: PSUM_W]);
    chk("rsp_valid", rsp_valid_o, m_rv);
    if (m_rv) begin
      chk("rsp_id", rsp_id_o, m_rid);
      chk("rsp_data", rsp_data_o, m_rdata);
      chk("rsp_err", rsp_err_o, m_rerr);
    end
  end

  // Event monitor for the literal checks.
  int vcount = 0, rsp_cnt = 0, low_run = 0;
  bit seen_busy = 1'b0;
  logic [NREQ-1:0] prev_gnt = '0;
  int glog[$];
  int gaps[$];
  initial forever begin
    @(negedge clk);
    vcount += int'(ppu_valid_o);
    if (rsp_valid_o) rsp_cnt++;
    if (gnt_o != '0 && prev_gnt == '0)
      for (int k = 0; k < NREQ; k++) if (gnt_o[k]) glog.push_back(k);
    prev_gnt = gnt_o;
    if (!busy_o) low_run++;
    else begin
      if (seen_busy && low_run > 0) gaps.push_back(low_run);
      low_run = 0;
      seen_busy = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic set_beat(input int r, input int b, input bit v);
    req_psum_valid_i[r] = v;
    req_psum_i[r*PSUM_W +: PSUM_W] = {12{8'(r + 1), 8'(b), 16'hC0DE}};
  endtask

  task automatic wait_gnt(input int r);
    for (int t = 0; t < 20 && !gnt_o[r]; t++) tick();
    chk("gnt_wait", gnt_o[r], 1);
  endtask

  task automatic stream(input int r, input int gap_at, input int gap_len, input int nbeats);
    wait_gnt(r);
    for (int b = 0; b < nbeats; b++) begin
      if (b == gap_at) begin req_psum_valid_i[r] = 1'b0; repeat (gap_len) tick(); end
      set_beat(r, b, 1'b1);
      tick();
    end
    req_psum_valid_i[r] = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid_o && n < TIMEOUT + 20) begin tick(); n++; end
    chk("rsp_wait", rsp_valid_o, 1);
  endtask

  task automatic pulse_done(input logic [127:0] d);
    ppu_data_i = d; ppu_done_i = 1'b1; tick(); ppu_done_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_i = '0; req_psum_valid_i = '0; ppu_done_i = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  int n, rc;

  initial begin
    // Test 1: single job, back-to-back beats, done 5 cycles after last beat.
    do_reset();
    chk("t0_reset_gnt", gnt_o, 0);
    chk("t0_reset_busy", busy_o, 0);
    vcount = 0; rc = rsp_cnt;
    req_i = 2'b01;
    tick();
    chk("t1_gnt_cycle1", gnt_o, 2'b01);
    req_i = '0;
    stream(0, -1, 0, 16);
    chk("t1_beats", vcount, 16);
    repeat (4) tick();
    pulse_done({16{8'hA5}});
    wait_rsp(n);
    chk("t1_rsp_id", rsp_id_o, 0);
    chk("t1_rsp_data", rsp_data_o, {16{8'hA5}});
    chk("t1_rsp_err", rsp_err_o, 0);
    repeat (2) tick();
    chk("t1_rsp_count", rsp_cnt - rc, 1);

    // Test 2: both requesting for three jobs -> 0,1,0 with one idle cycle between.
    do_reset();
    glog.delete(); gaps.delete(); seen_busy = 1'b0; low_run = 0;
    req_i = 2'b11;
    for (int j = 0; j < 3; j++) begin
      stream((j == 1) ? 1 : 0, -1, 0, 16);
      pulse_done(128'(j + 7));
      wait_rsp(n);
      chk("t2_rsp_id", rsp_id_o, (j == 1) ? 1 : 0);
      if (j == 2) req_i = '0;
      tick();
    end
    repeat (3) tick();
    chk("t2_grant_count", glog.size(), 3);
    while (glog.size() < 3) glog.push_back(9);
    chk("t2_grant0", glog[0], 0);
    chk("t2_grant1", glog[1], 1);
    chk("t2_grant2", glog[2], 0);
    chk("t2_gap_count", gaps.size(), 2);
    while (gaps.size() < 2) gaps.push_back(0);
    chk("t2_gap0", gaps[0], 1);
    chk("t2_gap1", gaps[1], 1);

    // Test 3/4: gap between beats 7 and 8, foreign valid noise, config change mid-job.
    do_reset();
    vcount = 0;
    set_beat(1, 99, 1'b1);
    req_cfg_i = {16'h1111, 16'h3805};
    req_i = 2'b01;
    wait_gnt(0);
    req_cfg_i[15:0] = 16'h4000;
    req_i = '0;
    chk("t4_scale_grant", ppu_scale_o, 8'h38);
    chk("t4_bias_grant", ppu_bias_o, 8'h05);
    stream(0, 8, 3, 16);
    chk("t3_beats", vcount, 16);
    chk("t3_no_early_rsp", rsp_valid_o, 0);
    pulse_done(128'h1234_5678);
    chk("t3_wait_after_beat15", rsp_valid_o, 1);
    chk("t3_rsp_data", rsp_data_o, 128'h1234_5678);
    chk("t4_scale_resp", ppu_scale_o, 8'h38);
    chk("t4_bias_resp", ppu_bias_o, 8'h05);
    tick();
    req_psum_valid_i[1] = 1'b0;

    // Test 5: timeout, then a stray done in IDLE.
    do_reset();
    ppu_data_i = '1;
    req_i = 2'b01;
    wait_gnt(0);
    req_i = '0;
    stream(0, -1, 0, 16);
    wait_rsp(n);
    chk("t5_timeout_cycles", n, 1023);
    chk("t5_err", rsp_err_o, 1);
    chk("t5_data_zero", rsp_data_o, 0);
    tick();
    rc = rsp_cnt;
    pulse_done('1);
    repeat (3) tick();
    chk("t5_stray_done_rsp", rsp_cnt - rc, 0);
    chk("t5_stray_done_busy", busy_o, 0);

    // Test 6: reset during a job owned by requester 1.
    do_reset();
    req_i = 2'b01;
    wait_gnt(0);
    req_i = '0;
    stream(0, -1, 0, 16);
    pulse_done(128'h55);
    wait_rsp(n);
    tick();
    req_i = 2'b11;
    wait_gnt(1);
    chk("t6_gnt_req1", gnt_o, 2'b10);
    stream(1, -1, 0, 9);
    set_beat(1, 9, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t6_async_gnt", gnt_o, 0);
    chk("t6_async_busy", busy_o, 0);
    chk("t6_async_scale", ppu_scale_o, 0);
    chk("t6_async_bias", ppu_bias_o, 0);
    chk("t6_async_valid", ppu_valid_o, 0);
    chk("t6_async_rsp", rsp_valid_o, 0);
    req_psum_valid_i = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    wait_gnt(0);
    chk("t6_regrant_req0", gnt_o, 2'b01);
    req_i = '0;
    vcount = 0;
    stream(0, -1, 0, 16);
    chk("t6_beats", vcount, 16);
    pulse_done(128'hBEEF);
    wait_rsp(n);
    chk("t6_rsp_id", rsp_id_o, 0);
    chk("t6_rsp_data", rsp_data_o, 128'hBEEF);
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    n_total++;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
